// File: rtl/windowed_sequence_adder.sv
`default_nettype none
// ============================================================================
// Module      : windowed_sequence_adder
// Description : Moving-window accumulator. Keeps the last 2^N accepted
//               samples in a ring buffer and maintains their running sum
//               incrementally (add newest, subtract evicted). Also provides
//               the sum divided by 2^N and the window fill level.
//
// Ports
//   clk          in   rising-edge clock
//   rst_n        in   asynchronous active-low reset
//   clear        in   synchronous clear of the whole window (beats in_valid)
//   in_valid     in   in_data carries a sample this cycle
//   in_data      in   [DATA_WIDTH-1:0] sample
//   out_valid    out  high for the cycle following each accepted sample
//   out_sum      out  [DATA_WIDTH+N-1:0] sum of the last 2^N samples
//   out_avg      out  [DATA_WIDTH-1:0] out_sum / 2^N (floor)
//   fill_count   out  [N:0] samples in window, saturates at 2^N
//   window_full  out  fill_count == 2^N
//
// Revision    : 1.0 - initial release
// ============================================================================
module windowed_sequence_adder #(
  parameter int DATA_WIDTH = 10,
  parameter int N          = 3,
  parameter bit SIGNED     = 1'b0
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    clear,
  input  logic                    in_valid,
  input  logic [DATA_WIDTH-1:0]   in_data,
  output logic                    out_valid,
  output logic [DATA_WIDTH+N-1:0] out_sum,
  output logic [DATA_WIDTH-1:0]   out_avg,
  output logic [N:0]              fill_count,
  output logic                    window_full
);

  localparam int             DEPTH  = 1 << N;
  localparam int             SUM_W  = DATA_WIDTH + N;
  localparam logic [N:0]     FULL   = (N+1)'(DEPTH);
  localparam logic [N:0]     FILL_1 = (N+1)'(1);
  localparam logic [N-1:0]   WP_1   = N'(1);

  // Widen a sample to the accumulator width; sign bit replicated only in
  // two's complement mode.
  function automatic logic [SUM_W-1:0] ext(input logic [DATA_WIDTH-1:0] v);
    ext = {{N{SIGNED && v[DATA_WIDTH-1]}}, v};
  endfunction

  logic [DATA_WIDTH-1:0] buf_q [DEPTH];
  logic [DATA_WIDTH-1:0] buf_d [DEPTH];
  logic [N-1:0]          wp_q, wp_d;
  logic [SUM_W-1:0]      sum_q, sum_d;
  logic [N:0]            fill_q, fill_d;
  logic                  out_valid_q, out_valid_d;

  always_comb begin
    for (int i = 0; i < DEPTH; i++) buf_d[i] = buf_q[i];
    wp_d        = wp_q;
    sum_d       = sum_q;
    fill_d      = fill_q;
    out_valid_d = 1'b0;

    if (clear) begin
      // Zeroed slots are what makes the partial sum correct while filling.
      for (int i = 0; i < DEPTH; i++) buf_d[i] = '0;
      wp_d   = '0;
      sum_d  = '0;
      fill_d = '0;
    end else if (in_valid) begin
      buf_d[wp_q] = in_data;
      wp_d        = wp_q + WP_1;
      // Modular arithmetic: the true window sum always fits in SUM_W bits,
      // so intermediate wrap-around cancels out.
      sum_d       = sum_q + ext(in_data) - ext(buf_q[wp_q]);
      if (fill_q != FULL) fill_d = fill_q + FILL_1;
      out_valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) buf_q[i] <= '0;
      wp_q        <= '0;
      sum_q       <= '0;
      fill_q      <= '0;
      out_valid_q <= 1'b0;
    end else begin
      for (int i = 0; i < DEPTH; i++) buf_q[i] <= buf_d[i];
      wp_q        <= wp_d;
      sum_q       <= sum_d;
      fill_q      <= fill_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign out_valid   = out_valid_q;
  assign out_sum     = sum_q;
  assign fill_count  = fill_q;
  assign window_full = (fill_q == FULL);
  // Dropping the low N bits and keeping exactly DATA_WIDTH bits gives the
  // same result for a logical and an arithmetic shift, so one slice covers
  // both SIGNED modes.
  assign out_avg     = sum_q[SUM_W-1:N];

endmodule
`default_nettype wire

// File: tb/tb_windowed_sequence_adder.sv
`default_nettype none
// ============================================================================
// Module      : tb_windowed_sequence_adder
// Description : Scoreboard bench for windowed_sequence_adder. An unsigned and
//               a signed instance share one stimulus stream; a queue-based
//               window model supplies expected results.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_windowed_sequence_adder;

  localparam int DW    = 10;
  localparam int N     = 3;
  localparam int DEPTH = 8;
  localparam int SW    = DW + N;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          clear = 1'b0;
  logic          in_valid = 1'b0;
  logic [DW-1:0] in_data = '0;

  logic          ov_u, ov_s;
  logic [SW-1:0] sum_u, sum_s;
  logic [DW-1:0] avg_u, avg_s;
  logic [N:0]    fill_u, fill_s;
  logic          full_u, full_s;

  windowed_sequence_adder #(.DATA_WIDTH(DW), .N(N), .SIGNED(1'b0)) u_dut_u (
    .clk(clk), .rst_n(rst_n), .clear(clear), .in_valid(in_valid),
    .in_data(in_data), .out_valid(ov_u), .out_sum(sum_u), .out_avg(avg_u),
    .fill_count(fill_u), .window_full(full_u)
  );

  windowed_sequence_adder #(.DATA_WIDTH(DW), .N(N), .SIGNED(1'b1)) u_dut_s (
    .clk(clk), .rst_n(rst_n), .clear(clear), .in_valid(in_valid),
    .in_data(in_data), .out_valid(ov_s), .out_sum(sum_s), .out_avg(avg_s),
    .fill_count(fill_s), .window_full(full_s)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [SW-1:0] su;
    logic [SW-1:0] ss;
    logic [DW-1:0] au;
    logic [DW-1:0] as_v;
  } exp_t;

  exp_t sb[$];
  int   win[$];
  int   compared = 0;
  int   mismatched = 0;
  bit   done = 1'b0;

  // Model state: window as it stands after the most recent clock edge.
  logic [SW-1:0] m_su = '0, m_ss = '0;
  logic [DW-1:0] m_au = '0, m_as = '0;
  int            m_fill = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t",
               name, act, act, exp, exp, $time);
    end
  endtask

  function automatic void model_update();
    int su, ss, au, as_i;
    su = 0; ss = 0;
    foreach (win[i]) begin
      su += win[i];
      ss += (win[i] >= (1 << (DW-1))) ? win[i] - (1 << DW) : win[i];
    end
    au   = su / DEPTH;
    as_i = (ss >= 0) ? ss / DEPTH : -((-ss + DEPTH - 1) / DEPTH);
    m_su   = su[SW-1:0];
    m_ss   = ss[SW-1:0];
    m_au   = au[DW-1:0];
    m_as   = as_i[DW-1:0];
    m_fill = win.size();
  endfunction

  // One clock of stimulus. Inputs change 1 time unit after the edge.
  task automatic step(input bit v, input logic [DW-1:0] d, input bit c);
    exp_t e;
    in_valid = v;
    in_data  = d;
    clear    = c;
    @(posedge clk);
    if (c) begin
      win.delete();
      model_update();
    end else if (v) begin
      win.push_back(int'(d));
      if (win.size() > DEPTH) void'(win.pop_front());
      model_update();
      e.su = m_su; e.ss = m_ss; e.au = m_au; e.as_v = m_as;
      sb.push_back(e);
    end
    #1;
    in_valid = 1'b0;
    clear    = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_valid_u"}, 32'(ov_u), 0);
    chk({tag, "_sum_u"},   32'(sum_u), 0);
    chk({tag, "_avg_u"},   32'(avg_u), 0);
    chk({tag, "_fill_u"},  32'(fill_u), 0);
    chk({tag, "_full_u"},  32'(full_u), 0);
    chk({tag, "_valid_s"}, 32'(ov_s), 0);
    chk({tag, "_sum_s"},   32'(sum_s), 0);
    chk({tag, "_fill_s"},  32'(fill_s), 0);
  endtask

  // Mid-stream asynchronous reset; also holds in_valid high across an edge
  // while in reset to show nothing is accepted.
  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    check_all_zero("async_reset");
    win.delete();
    sb.delete();
    model_update();
    in_valid = 1'b1;
    in_data  = 10'd55;
    @(posedge clk);
    #1;
    rst_n    = 1'b1;
    in_valid = 1'b0;
  endtask

  // Monitor: pops on out_valid, otherwise checks that outputs hold.
  always @(negedge clk) begin
    if (rst_n && !done) begin
      exp_t e;
      chk("valid_u", 32'(ov_u), 32'(sb.size() > 0));
      chk("valid_s", 32'(ov_s), 32'(sb.size() > 0));
      if (ov_u && sb.size() > 0) begin
        e = sb.pop_front();
        chk("sum_u", 32'(sum_u), 32'(e.su));
        chk("avg_u", 32'(avg_u), 32'(e.au));
        chk("sum_s", 32'(sum_s), 32'(e.ss));
        chk("avg_s", 32'(avg_s), 32'(e.as_v));
      end else begin
        if (sb.size() > 0) void'(sb.pop_front());
        chk("hold_sum_u", 32'(sum_u), 32'(m_su));
        chk("hold_sum_s", 32'(sum_s), 32'(m_ss));
        chk("hold_avg_u", 32'(avg_u), 32'(m_au));
      end
      chk("fill_u", 32'(fill_u), 32'(m_fill));
      chk("fill_s", 32'(fill_s), 32'(m_fill));
      chk("full_u", 32'(full_u), 32'(m_fill == DEPTH));
      chk("full_s", 32'(full_s), 32'(m_fill == DEPTH));
    end
  end

  initial begin
    // Power-up reset state
    #2;
    check_all_zero("por");
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Samples 1..8 then 9,10 (wrap and eviction)
    for (int i = 1; i <= 8; i++) step(1'b1, DW'(i), 1'b0);
    @(negedge clk); #1;
    chk("seq8_sum", 32'(sum_u), 36);
    chk("seq8_avg", 32'(avg_u), 4);
    chk("seq8_full", 32'(full_u), 1);
    step(1'b1, 10'd9, 1'b0);
    step(1'b1, 10'd10, 1'b0);
    @(negedge clk); #1;
    chk("wrap_sum", 32'(sum_u), 52);
    chk("wrap_fill", 32'(fill_u), 8);

    // Gap pattern 5,x,x,7
    step(1'b0, '0, 1'b1);
    step(1'b1, 10'd5, 1'b0);
    step(1'b0, 10'd99, 1'b0);
    step(1'b0, 10'd99, 1'b0);
    step(1'b1, 10'd7, 1'b0);
    @(negedge clk); #1;
    chk("gap_sum", 32'(sum_u), 12);

    // Max-value samples, both arithmetic modes
    step(1'b0, '0, 1'b1);
    for (int i = 0; i < 8; i++) step(1'b1, 10'h3FF, 1'b0);
    @(negedge clk); #1;
    chk("max_sum_u", 32'(sum_u), 8184);
    chk("max_avg_u", 32'(avg_u), 1023);
    chk("neg_sum_s", 32'(sum_s), 32'h1FF8);
    chk("neg_avg_s", 32'(avg_s), 32'h3FF);
    step(1'b1, 10'd7, 1'b0);
    @(negedge clk); #1;
    chk("neg_evict_sum_s", 32'(sum_s), 0);

    // Clear colliding with a valid sample
    step(1'b1, 10'd300, 1'b1);
    @(negedge clk); #1;
    chk("clr_sum", 32'(sum_u), 0);
    chk("clr_fill", 32'(fill_u), 0);
    chk("clr_valid", 32'(ov_u), 0);

    // Randomized traffic with occasional clears and one async reset
    for (int n = 0; n < 600; n++) begin
      if (n == 300) do_reset();
      else step(($urandom_range(99) < 75), DW'($urandom),
                ($urandom_range(99) < 3));
    end

    @(negedge clk); #1;
    done = 1'b1;
    chk("sb_drained", 32'(sb.size()), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/windowed_sequence_adder.md
WINDOWED_SEQUENCE_ADDER -- requirements
Module: windowed_sequence_adder

Interface
REQ-001 Parameter DATA_WIDTH, default 10, SHALL set the sample width in bits.
REQ-002 Parameter N, default 3, SHALL set the window depth to 2^N samples; N SHALL be at least 1.
REQ-003 Parameter SIGNED, default 0, SHALL select arithmetic: 0 = unsigned, 1 = two's complement.
REQ-004 clk  input  1  single clock; all state changes on its rising edge.
REQ-005 rst_n  input  1  asynchronous, active-low reset.
REQ-006 clear  input  1  synchronous window clear.
REQ-007 in_valid  input  1  in_data is a sample to accept this cycle.
REQ-008 in_data  input  DATA_WIDTH  sample value.
REQ-009 out_valid  output  1  out_sum/out_avg were updated by the most recent edge.
REQ-010 out_sum  output  DATA_WIDTH+N  sum of the last 2^N accepted samples.
REQ-011 out_avg  output  DATA_WIDTH  out_sum divided by 2^N.
REQ-012 fill_count  output  N+1  accepted samples in window, saturating at 2^N.
REQ-013 window_full  output  1  high when fill_count equals 2^N.

Function
REQ-014 Block SHALL hold a 2^N-entry ring buffer with an N-bit write pointer that wraps from 2^N-1 to 0.
REQ-015 Sample accepted when in_valid=1 and clear=0; on acceptance buffer[wp] <= in_data, wp <= wp+1.
REQ-016 On acceptance running sum <= sum + ext(in_data) - ext(buffer[wp]); ext = zero-extend (SIGNED=0) or sign-extend (SIGNED=1) to DATA_WIDTH+N.
REQ-017 out_sum SHALL equal the running sum register; latency from accepted sample to updated out_sum = 1 clock.
REQ-018 out_valid SHALL be high for exactly the cycle following each accepted sample, low otherwise.
REQ-019 When no sample is accepted, buffer, wp, sum, fill_count and out_sum SHALL hold.
REQ-020 Unfilled buffer slots SHALL read as zero, so before window_full out_sum is the partial sum of samples received.
REQ-021 out_avg SHALL be out_sum shifted right by N: logical when SIGNED=0, arithmetic (round toward minus infinity) when SIGNED=1; divisor is always 2^N, also before window_full.
REQ-022 out_sum width DATA_WIDTH+N SHALL never overflow for any input sequence.
REQ-023 fill_count SHALL increment on each acceptance and saturate at 2^N; window_full = (fill_count == 2^N).
REQ-024 clear=1 at an edge SHALL zero all buffer entries, wp, sum, fill_count, out_valid.
REQ-025 clear and in_valid both high: clear wins, sample discarded, out_valid low next cycle.
REQ-026 Continuous in_valid SHALL sustain one accepted sample per cycle with no bubbles.

Reset
REQ-027 rst_n=0 SHALL immediately, without a clock edge, force buffer, wp, sum, fill_count, out_sum, out_avg, out_valid, window_full to zero.
REQ-028 While rst_n=0 no sample SHALL be accepted; first acceptance is at the first rising edge with rst_n=1 and in_valid=1.
REQ-029 Reset asserted mid-stream SHALL discard all window contents; post-reset behaviour is identical to power-up.

Verification (DATA_WIDTH=10, N=3 unless stated)
REQ-030 Reset, then in_data 1..8 on consecutive cycles -> out_sum 1,3,6,10,15,21,28,36; window_full high after 8th; out_avg 4.
REQ-031 Continue with 9,10 -> out_sum 44 then 52 (oldest 1,2 evicted; wrap verified); fill_count stays 8.
REQ-032 in_valid toggled 1,0,0,1 with data 5,x,x,7 -> out_valid 1,0,0,1 pattern delayed one cycle; out_sum 5 held through gap, then 12.
REQ-033 Eight samples of 1023 -> out_sum 8184, out_avg 1023, no overflow.
REQ-034 SIGNED=1: eight samples 0x3FF (-1) -> out_sum 0x1FF8 (-8), out_avg 0x3FF (-1); then sample 7 -> out_sum 0.
REQ-035 Mid-stream clear=1 with in_valid=1 -> next cycle out_sum 0, fill_count 0, out_valid 0; separate mid-stream rst_n low -> all outputs 0 before next edge.
